mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 41 ++++
 rtl/mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_if
// Description : Request/response and data-memory bundle for mem_ctrl.
//               master = upstream requester, slave = controller,
//               memory = data-memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [2:0]   req_addr;
  logic [255:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [255:0] rsp_rdata;
  logic         rsp_err;
  logic [2:0]   mem_pointer;
  logic         mem_write;
  logic         mem_read;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_pointer, mem_write, mem_read, mem_wdata
  );

  modport memory (
    input  mem_pointer, mem_write, mem_read, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Single-outstanding load/store controller in front of a
//               synchronous-read data memory. Out-of-range addresses are
//               answered with an error and never touch the memory.
//               Optional macro MEM_CTRL_VERIFY_EN adds a read-back check
//               after every store (WR->VRD->VCAP->RESP).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int NUM_WORDS = 6
) (
  input  logic       clk,
  input  logic       reset,
  mem_ctrl_if.slave  bus
);

  localparam logic [3:0] c_NUM_WORDS = 4'(NUM_WORDS);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_WR   = 3'd1;
  localparam logic [2:0] c_ST_RD   = 3'd2;
  localparam logic [2:0] c_ST_CAP  = 3'd3;
  localparam logic [2:0] c_ST_RESP = 3'd4;
`ifdef MEM_CTRL_VERIFY_EN
  localparam logic [2:0] c_ST_VRD  = 3'd5;
  localparam logic [2:0] c_ST_VCAP = 3'd6;
`endif

  logic [2:0]   r_state;
  logic         r_req_ready;
  logic         r_rsp_valid;
  logic [255:0] r_rsp_rdata;
  logic         r_rsp_err;
  logic [2:0]   r_mem_pointer;
  logic         r_mem_write;
  logic         r_mem_read;
  logic [255:0] r_mem_wdata;

  logic         w_addr_bad;

  // Address range check on the request as presented
  assign w_addr_bad = ({1'b0, bus.req_addr} >= c_NUM_WORDS);

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.mem_pointer = r_mem_pointer;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_wdata   = r_mem_wdata;

  // Transaction FSM; every output is a register so strobes are glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_ST_IDLE;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_mem_pointer <= '0;
      r_mem_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_wdata   <= '0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            if (w_addr_bad) begin
              r_state     <= c_ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end else if (bus.req_write) begin
              r_state       <= c_ST_WR;
              r_mem_pointer <= bus.req_addr;
              r_mem_wdata   <= bus.req_wdata;
              r_mem_write   <= 1'b1;
            end else begin
              r_state       <= c_ST_RD;
              r_mem_pointer <= bus.req_addr;
              r_mem_read    <= 1'b1;
            end
          end else begin
            // First edge after reset release raises ready
            r_req_ready <= 1'b1;
          end
        end
        c_ST_WR: begin
`ifdef MEM_CTRL_VERIFY_EN
          r_state    <= c_ST_VRD;
          r_mem_read <= 1'b1;
`else
          r_state     <= c_ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
`endif
        end
        c_ST_RD: begin
          // Memory returns data one edge after the read strobe
          r_state <= c_ST_CAP;
        end
        c_ST_CAP: begin
          r_state     <= c_ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= bus.mem_rdata;
          r_rsp_err   <= 1'b0;
        end
`ifdef MEM_CTRL_VERIFY_EN
        c_ST_VRD: begin
          r_state <= c_ST_VCAP;
        end
        c_ST_VCAP: begin
          // The stored data is still held on mem_wdata for the comparison
          r_state     <= c_ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= bus.mem_rdata;
          r_rsp_err   <= (bus.mem_rdata != r_mem_wdata);
        end
`endif
        c_ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= c_ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= c_ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a behavioural
//               synchronous-read data memory. Adapts expected latency and
//               store response to MEM_CTRL_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

`ifdef MEM_CTRL_VERIFY_EN
  localparam bit c_VERIFY = 1'b1;
  localparam int c_ST_LAT = 4;
`else
  localparam bit c_VERIFY = 1'b0;
  localparam int c_ST_LAT = 2;
`endif

  logic clk;
  logic reset;
  mem_ctrl_if bus();

  mem_ctrl #(.NUM_WORDS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory, optionally corrupting read data
  logic [255:0] r_mem [8];
  logic [255:0] r_mem_rdata;
  logic         r_corrupt;
  assign bus.mem_rdata = r_mem_rdata;

  always @(posedge clk) begin
    if (bus.mem_write === 1'b1) r_mem[bus.mem_pointer] <= bus.mem_wdata;
    if (bus.mem_read === 1'b1)
      r_mem_rdata <= r_mem[bus.mem_pointer] ^ (r_corrupt ? {256{1'b1}} : 256'd0);
  end

  // Strobe pulse counters
  int wr_cnt, rd_cnt, both_cnt;
  initial begin wr_cnt = 0; rd_cnt = 0; both_cnt = 0; end
  always @(posedge clk) begin
    if (bus.mem_write === 1'b1) wr_cnt <= wr_cnt + 1;
    if (bus.mem_read === 1'b1) rd_cnt <= rd_cnt + 1;
    if (bus.mem_write === 1'b1 && bus.mem_read === 1'b1) both_cnt <= both_cnt + 1;
  end

  int n_checks, n_errors;
  logic [255:0] exp_mem [8];

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] init_word(input int i);
    logic [7:0] b;
    b = 8'h10 + 8'(i);
    return {32{b}};
  endfunction

  // One full request/response exchange; optional response stall with a
  // competing request held on the bus
  task automatic txn(input bit wr, input logic [2:0] addr, input logic [255:0] wd,
                     input int stall, input logic [255:0] exp_rd,
                     output logic [255:0] rd, output bit err, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) check("accept_timeout", 256'(1'b0), 256'(1'b1));
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wd;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) check("rsp_timeout", 256'(1'b0), 256'(1'b1));
    for (int s = 0; s < stall; s++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 3'd1;
      bus.req_wdata = {256{1'b1}};
      @(posedge clk); #1;
      check("stall_rsp_valid", 256'(bus.rsp_valid), 256'(1'b1));
      check("stall_rsp_rdata", bus.rsp_rdata, exp_rd);
      check("stall_req_ready", 256'(bus.req_ready), 256'(1'b0));
    end
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] rd, v, aaa;
    bit err;
    int lat, w0, r0;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    r_corrupt = 1'b0;
    r_mem_rdata = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r_mem[i]   <= init_word(i);
      exp_mem[i] = init_word(i);
    end

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_req_ready", 256'(bus.req_ready), 256'(1'b0));
    check("rst_rsp_valid", 256'(bus.rsp_valid), 256'(1'b0));
    check("rst_rsp_err", 256'(bus.rsp_err), 256'(1'b0));
    check("rst_rsp_rdata", bus.rsp_rdata, 256'd0);
    check("rst_strobes", 256'({bus.mem_write, bus.mem_read}), 256'(2'b00));
    check("rst_pointer", 256'(bus.mem_pointer), 256'(3'd0));
    check("rst_wdata", bus.mem_wdata, 256'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 256'(bus.req_ready), 256'(1'b1));

    // Basic store then load at address 0
    v = {64{4'h5}};
    w0 = wr_cnt; r0 = rd_cnt;
    txn(1'b1, 3'd0, v, 0, '0, rd, err, lat);
    exp_mem[0] = v;
    check("st0_err", 256'(err), 256'(1'b0));
    check("st0_rdata", rd, c_VERIFY ? v : 256'd0);
    check("st0_lat", 256'(lat), 256'(c_ST_LAT));
    check("st0_wr_pulses", 256'(wr_cnt - w0), 256'(1));
    check("st0_rd_pulses", 256'(rd_cnt - r0), 256'(c_VERIFY ? 1 : 0));
    w0 = wr_cnt; r0 = rd_cnt;
    txn(1'b0, 3'd0, '0, 0, '0, rd, err, lat);
    check("ld0_rdata", rd, v);
    check("ld0_err", 256'(err), 256'(1'b0));
    check("ld0_lat", 256'(lat), 256'(3));
    check("ld0_rd_pulses", 256'(rd_cnt - r0), 256'(1));
    check("ld0_wr_pulses", 256'(wr_cnt - w0), 256'(0));

    // Each address in turn: store AAAA, then read back all six words
    aaa = {64{4'hA}};
    for (int a = 0; a < 6; a++) begin
      txn(1'b1, 3'(a), aaa, 0, '0, rd, err, lat);
      exp_mem[a] = aaa;
      for (int b = 0; b < 6; b++) begin
        txn(1'b0, 3'(b), '0, 0, '0, rd, err, lat);
        check($sformatf("sweep_w%0d_r%0d", a, b), rd, exp_mem[b]);
      end
    end

    // Walking byte at address 3
    for (int k = 0; k < 32; k++) begin
      v = 256'hAA << (8 * k);
      txn(1'b1, 3'd3, v, 0, '0, rd, err, lat);
      exp_mem[3] = v;
      txn(1'b0, 3'd3, '0, 0, '0, rd, err, lat);
      check($sformatf("walk_%0d", k), rd, v);
    end
    check("idle_pointer_hold", 256'(bus.mem_pointer), 256'(3'd3));
    check("idle_wdata_hold", bus.mem_wdata, 256'hAA << 248);

    // Out-of-range addresses, both directions
    for (int a = 6; a < 8; a++) begin
      for (int d = 0; d < 2; d++) begin
        w0 = wr_cnt; r0 = rd_cnt;
        txn(d[0], 3'(a), {256{1'b1}}, 0, '0, rd, err, lat);
        check($sformatf("oor_err_a%0d_w%0d", a, d), 256'(err), 256'(1'b1));
        check($sformatf("oor_rdata_a%0d_w%0d", a, d), rd, 256'd0);
        check($sformatf("oor_lat_a%0d_w%0d", a, d), 256'(lat), 256'(1));
        check($sformatf("oor_strobes_a%0d_w%0d", a, d), 256'((wr_cnt - w0) + (rd_cnt - r0)), 256'(0));
      end
    end

    // Response back-pressure with a competing store held on the bus
    w0 = wr_cnt;
    txn(1'b0, 3'd3, '0, 5, exp_mem[3], rd, err, lat);
    check("stall_final_rdata", rd, exp_mem[3]);
    check("stall_no_write", 256'(wr_cnt - w0), 256'(0));
    v = 256'h1234_5678_9ABC_DEF0;
    txn(1'b1, 3'd1, v, 0, '0, rd, err, lat);
    exp_mem[1] = v;
    txn(1'b0, 3'd1, '0, 0, '0, rd, err, lat);
    check("post_stall_load", rd, v);

    // Reset in the RD cycle aborts the load
    r0 = rd_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 3'd2;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("abort_rd_strobe_on", 256'(bus.mem_read), 256'(1'b1));
    #1 reset = 1'b0;
    #1;
    check("abort_rd_strobe_off", 256'(bus.mem_read), 256'(1'b0));
    check("abort_rsp_valid", 256'(bus.rsp_valid), 256'(1'b0));
    @(negedge clk); reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_rsp", 256'(bus.rsp_valid), 256'(1'b0));
    end
    check("abort_ready", 256'(bus.req_ready), 256'(1'b1));
    check("abort_no_rd_sample", 256'(rd_cnt - r0), 256'(0));

    // Store with corrupted read-back memory
    r_corrupt = 1'b1;
    v = {32{8'h3C}};
    txn(1'b1, 3'd2, v, 0, '0, rd, err, lat);
    r_corrupt = 1'b0;
    check("verify_err", 256'(err), 256'(c_VERIFY));
    check("verify_rdata", rd, c_VERIFY ? ~v : 256'd0);
    check("verify_lat", 256'(lat), 256'(c_ST_LAT));

    check("strobes_exclusive", 256'(both_cnt), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
